multi_debouncer: RTL and testbench

Parametrised N-channel debouncer for board push-buttons and switches feeding the camera control logic (capture, mode, and menu keys).

---
 rtl/multi_debouncer.sv | 156 +++++++++++++++
 tb/tb_multi_debouncer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multi_debouncer.sv
// N-channel push-button debouncer: 2-flop sync, optional inversion, stability filter,
// rise/fall pulses, plus long-press hold detection and optional auto-repeat.
module multi_debouncer #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned DEB_CYCLES  = 100_000,
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned RPT_CYCLES  = 0,
  parameter bit          ACTIVE_LOW  = 1'b0,
  parameter int unsigned CNT_W       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] hold,
  output logic [N_CH-1:0] rpt
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [1:0] ST_AFTER_HOLD = (RPT_CYCLES != 0) ? ST_REPEAT : ST_DONE;

  localparam int unsigned RPT_M1 = (RPT_CYCLES == 0) ? 0 : RPT_CYCLES - 1;

  localparam logic [CNT_W-1:0] DEB_TERM  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_TERM  = CNT_W'(RPT_M1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam longint unsigned CNT_LIM = 64'd1 << CNT_W;

  // Reject parameter sets the counters cannot represent.
  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("multi_debouncer: N_CH must be in 1..16");
  end
  if (CNT_W < 1 || CNT_W > 63) begin : g_bad_cntw
    $error("multi_debouncer: CNT_W must be in 1..63");
  end
  if (DEB_CYCLES < 2 || HOLD_CYCLES < 1) begin : g_bad_min
    $error("multi_debouncer: DEB_CYCLES must be >= 2 and HOLD_CYCLES >= 1");
  end
  if (64'(DEB_CYCLES) > CNT_LIM || 64'(HOLD_CYCLES) > CNT_LIM ||
      64'(RPT_CYCLES) > CNT_LIM) begin : g_bad_range
    $error("multi_debouncer: a cycle parameter exceeds 2**CNT_W");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             sync1_q, sync2_q, s;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]       state_q, state_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d, fall_q, fall_d;
    logic             hold_q, hold_d, rpt_q, rpt_d;

    assign s = sync2_q ^ ACTIVE_LOW;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q    <= ACTIVE_LOW;
        sync2_q    <= ACTIVE_LOW;
        deb_cnt_q  <= '0;
        hold_cnt_q <= '0;
        state_q    <= ST_IDLE;
        level_q    <= 1'b0;
        rise_q     <= 1'b0;
        fall_q     <= 1'b0;
        hold_q     <= 1'b0;
        rpt_q      <= 1'b0;
      end else begin
        sync1_q    <= in[i];
        sync2_q    <= sync1_q;
        deb_cnt_q  <= deb_cnt_d;
        hold_cnt_q <= hold_cnt_d;
        state_q    <= state_d;
        level_q    <= level_d;
        rise_q     <= rise_d;
        fall_q     <= fall_d;
        hold_q     <= hold_d;
        rpt_q      <= rpt_d;
      end
    end

    always_comb begin
      deb_cnt_d  = deb_cnt_q;
      level_d    = level_q;
      rise_d     = 1'b0;
      fall_d     = 1'b0;
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      hold_d     = 1'b0;
      rpt_d      = 1'b0;

      // Stability filter: any return to the current level restarts the count.
      if (s == level_q) begin
        deb_cnt_d = '0;
      end else if (deb_cnt_q == DEB_TERM) begin
        deb_cnt_d = '0;
        level_d   = s;
        rise_d    = s;
        fall_d    = ~s;
      end else begin
        deb_cnt_d = deb_cnt_q + CNT_ONE;
      end

      case (state_q)
        ST_IDLE: begin
          hold_cnt_d = '0;
          if (rise_d) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (hold_cnt_q == HOLD_TERM) begin
            hold_d     = 1'b1;
            hold_cnt_d = '0;
            state_d    = ST_AFTER_HOLD;
          end else begin
            hold_cnt_d = hold_cnt_q + CNT_ONE;
          end
        end
        ST_REPEAT: begin
          if (hold_cnt_q == RPT_TERM) begin
            rpt_d      = 1'b1;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + CNT_ONE;
          end
        end
        ST_DONE: hold_cnt_d = '0;
        default: begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
        end
      endcase

      // Release takes priority over a hold/repeat pulse due in the same cycle.
      if (fall_d) begin
        state_d    = ST_IDLE;
        hold_cnt_d = '0;
        hold_d     = 1'b0;
        rpt_d      = 1'b0;
      end
    end

    assign level[i] = level_q;
    assign rise[i]  = rise_q;
    assign fall[i]  = fall_q;
    assign hold[i]  = hold_q;
    assign rpt[i]   = rpt_q;
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer: expected event times are queued when stimulus
// is applied and every output of two DUT configurations is compared each cycle.
module tb_multi_debouncer;

  localparam int unsigned LAT  = 6;   // 2 sync + DEB_CYCLES(4)
  localparam int unsigned HOLD = 10;
  localparam int unsigned RPT  = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in_m, in_a;
  logic [1:0] lvl_m, rise_m, fall_m, hold_m, rpt_m;
  logic [1:0] lvl_a, rise_a, fall_a, hold_a, rpt_a;

  int unsigned cyc;
  int          vectors;
  int          miscompares;
  logic [1:0]  lvl_exp [2];

  typedef struct {
    int unsigned at;
    int unsigned unit;
    logic [1:0]  rise;
    logic [1:0]  fall;
    logic [1:0]  hold;
    logic [1:0]  rpt;
  } ev_t;

  ev_t sb[$];

  always #5 clk = ~clk;

  multi_debouncer #(
    .N_CH(2), .DEB_CYCLES(4), .HOLD_CYCLES(10), .RPT_CYCLES(5),
    .ACTIVE_LOW(1'b0), .CNT_W(8)
  ) dut_m (
    .clk(clk), .rst(rst), .in(in_m),
    .level(lvl_m), .rise(rise_m), .fall(fall_m), .hold(hold_m), .rpt(rpt_m)
  );

  multi_debouncer #(
    .N_CH(2), .DEB_CYCLES(4), .HOLD_CYCLES(10), .RPT_CYCLES(0),
    .ACTIVE_LOW(1'b1), .CNT_W(8)
  ) dut_a (
    .clk(clk), .rst(rst), .in(in_a),
    .level(lvl_a), .rise(rise_a), .fall(fall_a), .hold(hold_a), .rpt(rpt_a)
  );

  task automatic cmp(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push(input int unsigned at, input int unsigned u, input logic [1:0] r,
                      input logic [1:0] f, input logic [1:0] h, input logic [1:0] p);
    ev_t e;
    e.at = at; e.unit = u; e.rise = r; e.fall = f; e.hold = h; e.rpt = p;
    sb.push_back(e);
  endtask

  // Press applied at cycle c, released at cycle d: queue every event the press should make.
  task automatic sched_press(input int unsigned u, input logic [1:0] m, input int unsigned c,
                             input int unsigned d, input int unsigned per);
    int unsigned t, fe;
    t  = c + LAT;
    fe = d + LAT;
    push(t, u, m, 2'b00, 2'b00, 2'b00);
    if (t + HOLD < fe) begin
      push(t + HOLD, u, 2'b00, 2'b00, m, 2'b00);
      if (per != 0) begin
        for (int unsigned x = t + HOLD + per; x < fe; x += per)
          push(x, u, 2'b00, 2'b00, 2'b00, m);
      end
    end
    push(fe, u, 2'b00, m, 2'b00, 2'b00);
  endtask

  task automatic tick();
    logic [1:0] r [2];
    logic [1:0] f [2];
    logic [1:0] h [2];
    logic [1:0] p [2];
    @(posedge clk);
    cyc++;
    #1;
    for (int u = 0; u < 2; u++) begin
      r[u] = 2'b00; f[u] = 2'b00; h[u] = 2'b00; p[u] = 2'b00;
    end
    if (rst) begin
      sb.delete();
      lvl_exp[0] = 2'b00;
      lvl_exp[1] = 2'b00;
    end
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].at == cyc) begin
        r[sb[k].unit] |= sb[k].rise;
        f[sb[k].unit] |= sb[k].fall;
        h[sb[k].unit] |= sb[k].hold;
        p[sb[k].unit] |= sb[k].rpt;
        sb.delete(k);
      end
    end
    for (int u = 0; u < 2; u++) lvl_exp[u] = (lvl_exp[u] | r[u]) & ~f[u];
    cmp($sformatf("main.level@%0d", cyc), lvl_m,  lvl_exp[0]);
    cmp($sformatf("main.rise@%0d", cyc),  rise_m, r[0]);
    cmp($sformatf("main.fall@%0d", cyc),  fall_m, f[0]);
    cmp($sformatf("main.hold@%0d", cyc),  hold_m, h[0]);
    cmp($sformatf("main.rpt@%0d", cyc),   rpt_m,  p[0]);
    cmp($sformatf("al.level@%0d", cyc),   lvl_a,  lvl_exp[1]);
    cmp($sformatf("al.rise@%0d", cyc),    rise_a, r[1]);
    cmp($sformatf("al.fall@%0d", cyc),    fall_a, f[1]);
    cmp($sformatf("al.hold@%0d", cyc),    hold_a, h[1]);
    cmp($sformatf("al.rpt@%0d", cyc),     rpt_a,  p[1]);
  endtask

  initial begin
    cyc         = 0;
    vectors     = 0;
    miscompares = 0;
    lvl_exp[0]  = 2'b00;
    lvl_exp[1]  = 2'b00;
    rst  = 1'b1;
    in_m = 2'b11;
    in_a = 2'b11;

    // Reset with both main inputs high; both channels debounce after release.
    repeat (3) tick();
    rst = 1'b0;
    sched_press(0, 2'b11, cyc, cyc + 17, RPT);
    repeat (17) tick();
    in_m = 2'b00;
    repeat (12) tick();

    // Bounce: two 3-cycle high glitches, then a clean press on channel 0.
    in_m = 2'b01; repeat (3) tick();
    in_m = 2'b00; repeat (2) tick();
    in_m = 2'b01; repeat (3) tick();
    in_m = 2'b00; repeat (2) tick();
    in_m = 2'b01;
    sched_press(0, 2'b01, cyc, cyc + 20, RPT);
    repeat (20) tick();
    in_m = 2'b00;
    repeat (10) tick();

    // Long press with auto-repeat.
    in_m = 2'b01;
    sched_press(0, 2'b01, cyc, cyc + 40, RPT);
    repeat (40) tick();
    in_m = 2'b00;
    repeat (12) tick();

    // Release lands on the hold cycle, then a fresh press proves the FSM restarted.
    in_m = 2'b01;
    sched_press(0, 2'b01, cyc, cyc + 10, RPT);
    repeat (10) tick();
    in_m = 2'b00;
    repeat (10) tick();
    in_m = 2'b01;
    sched_press(0, 2'b01, cyc, cyc + 14, RPT);
    repeat (14) tick();
    in_m = 2'b00;
    repeat (10) tick();

    // Active-low instance, repeat disabled: press channel 1 by driving it low.
    in_a = 2'b01;
    sched_press(1, 2'b10, cyc, cyc + 30, 0);
    repeat (30) tick();
    in_a = 2'b11;
    repeat (10) tick();

    // Reset during WAIT_HOLD discards the press; it then re-debounces.
    in_m = 2'b01;
    push(cyc + LAT, 0, 2'b01, 2'b00, 2'b00, 2'b00);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sched_press(0, 2'b01, cyc, cyc + 25, RPT);
    repeat (25) tick();
    in_m = 2'b00;
    repeat (10) tick();

    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
